// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_tx_arbiter_if
// Purpose   : Bundles the requester handshake and the uart_tx control/status
//             signals of the uart_tx_arbiter.
//             slave  - the arbiter side (consumes requests, drives uart_tx)
//             master - the environment side (requesters + uart_tx)
// Signals   : req_valid[N_REQ]             requester has a byte pending
//             req_data[N_REQ*FRAME_BITS]   packed bytes, requester i at
//                                          [i*FRAME_BITS +: FRAME_BITS]
//             req_last[N_REQ]              byte closes a packet
//             req_ack[N_REQ]               one-hot capture pulse
//             tx_start                     start pulse to uart_tx
//             tx_data[FRAME_BITS]          byte to uart_tx
//             tx_status                    uart_tx busy flag
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int FRAME_BITS = 8
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*FRAME_BITS-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ack;
    logic                        tx_start;
    logic [FRAME_BITS-1:0]       tx_data;
    logic                        tx_status;

    modport slave (
        input  req_valid, req_data, req_last, tx_status,
        output req_ack, tx_start, tx_data
    );

    modport master (
        output req_valid, req_data, req_last, tx_status,
        input  req_ack, tx_start, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : uart_tx_arbiter
// Purpose   : Round-robin arbiter sharing one uart_tx serializer among N_REQ
//             byte producers. Captures one byte per grant, pulses tx_start,
//             follows tx_status through the frame and re-arbitrates once the
//             line is idle again.
// Ports     : clk            system clock
//             rst_n          asynchronous active-low reset
//             bus            uart_tx_arbiter_if.slave (requesters + uart_tx)
//             o_grant_id     index of the current/last granted requester
//             o_busy         arbiter not in IDLE
//             o_ack_timeout  1-cycle pulse: uart_tx never went busy
// Options   : UART_ARB_LOCK_EN - packet lock; a captured byte with req_last=0
//             keeps the grant on that requester until its last byte.
// Revision  : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int FRAME_BITS  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    uart_tx_arbiter_if.slave            bus,
    output logic [$clog2(N_REQ)-1:0]    o_grant_id,
    output logic                        o_busy,
    output logic                        o_ack_timeout
);
    localparam int IDW  = $clog2(N_REQ);
    localparam int CNTW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [IDW-1:0]  c_last_id = IDW'(N_REQ - 1);
    localparam logic [CNTW-1:0] c_cnt_max = CNTW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                r_state,   w_state_nxt;
    logic [IDW-1:0]        r_rr_ptr,  w_rr_nxt;
    logic [IDW-1:0]        r_grant_id, w_grant_nxt;
    logic [FRAME_BITS-1:0] r_tx_data, w_data_nxt;
    logic [N_REQ-1:0]      r_req_ack, w_ack_nxt;
    logic                  r_tx_start, w_start_nxt;
    logic                  r_ack_timeout, w_to_nxt;
    logic [CNTW-1:0]       r_cnt,     w_cnt_nxt;

    logic [N_REQ-1:0]      w_eligible;
    logic                  w_found;
    logic [IDW-1:0]        w_winner;
    logic [FRAME_BITS-1:0] w_req_byte [N_REQ];

    // Unpack the flat data bus so the winner's byte is a plain array read.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_req_byte[gi] = bus.req_data[gi*FRAME_BITS +: FRAME_BITS];
    end

`ifdef UART_ARB_LOCK_EN
    logic             r_lock, w_lock_nxt;
    logic [N_REQ-1:0] w_lock_mask;

    // While locked only the owning requester (always the last grant) may win.
    assign w_lock_mask = r_lock ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id) : '1;
    assign w_eligible  = bus.req_valid & w_lock_mask;
`else
    logic w_unused_last;

    assign w_eligible    = bus.req_valid;
    assign w_unused_last = ^bus.req_last;
`endif

    // Search starts one past the last winner and wraps, so the previous
    // winner has the lowest priority in the next round.
    always_comb begin : p_arbitrate
        logic [IDW-1:0] w_cand;
        w_cand   = r_rr_ptr;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = (w_cand == c_last_id) ? '0 : w_cand + 1'b1;
            if (!w_found && w_eligible[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant_id;
        w_data_nxt  = r_tx_data;
        w_ack_nxt   = '0;
        w_start_nxt = 1'b0;
        w_to_nxt    = 1'b0;
        w_cnt_nxt   = r_cnt;
`ifdef UART_ARB_LOCK_EN
        w_lock_nxt  = r_lock;
`endif
        case (r_state)
            S_IDLE: begin
                // A busy uart_tx (leftover or external) blocks arbitration.
                if (!bus.tx_status && w_found) begin
                    w_state_nxt         = S_ISSUE;
                    w_data_nxt          = w_req_byte[w_winner];
                    w_grant_nxt         = w_winner;
                    w_ack_nxt[w_winner] = 1'b1;
                    w_start_nxt         = 1'b1;
`ifdef UART_ARB_LOCK_EN
                    w_lock_nxt          = !bus.req_last[w_winner];
`endif
                end
            end
            S_ISSUE: begin
                w_rr_nxt    = r_grant_id;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.tx_status) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == c_cnt_max) begin
                    // Byte is dropped: it was already acknowledged.
                    w_to_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
`ifdef UART_ARB_LOCK_EN
                    w_lock_nxt  = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_status) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= c_last_id;
            r_grant_id    <= '0;
            r_tx_data     <= '0;
            r_req_ack     <= '0;
            r_tx_start    <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_cnt         <= '0;
`ifdef UART_ARB_LOCK_EN
            r_lock        <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_grant_id    <= w_grant_nxt;
            r_tx_data     <= w_data_nxt;
            r_req_ack     <= w_ack_nxt;
            r_tx_start    <= w_start_nxt;
            r_ack_timeout <= w_to_nxt;
            r_cnt         <= w_cnt_nxt;
`ifdef UART_ARB_LOCK_EN
            r_lock        <= w_lock_nxt;
`endif
        end
    end

    assign bus.req_ack    = r_req_ack;
    assign bus.tx_start   = r_tx_start;
    assign bus.tx_data    = r_tx_data;
    assign o_grant_id     = r_grant_id;
    assign o_busy         = (r_state != S_IDLE);
    assign o_ack_timeout  = r_ack_timeout;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_uart_tx_arbiter
// Purpose   : Directed self-checking bench for uart_tx_arbiter. A small
//             uart_tx stand-in serializes each started byte (start, 8 data
//             LSB first, stop, one clock per bit) and a line monitor decodes
//             the frames for comparison against hand-computed bytes.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int FB = 8;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic       ato;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter_if #(.N_REQ(N), .FRAME_BITS(FB)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .FRAME_BITS(FB), .ACK_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_grant_id   (grant),
        .o_busy       (busy),
        .o_ack_timeout(ato)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in, reset by the same net as the arbiter
    bit         model_dead = 1'b0;
    bit         force_busy = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_line = 1'b1;
    logic [8:0] m_sh = '0;
    int         m_cnt = 0;

    assign bus.tx_status = m_busy | force_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_line <= 1'b1; m_sh <= '0; m_cnt <= 0;
        end else if (!m_busy) begin
            if (bus.tx_start && !model_dead) begin
                m_busy <= 1'b1; m_line <= 1'b0;
                m_sh <= {1'b1, bus.tx_data}; m_cnt <= 9;
            end
        end else if (m_cnt != 0) begin
            m_line <= m_sh[0]; m_sh <= m_sh >> 1; m_cnt <= m_cnt - 1;
        end else begin
            m_busy <= 1'b0; m_line <= 1'b1;
        end
    end

    // Line monitor: entries are {framing_ok, byte}
    logic [15:0] mon_bits = '0;
    int          mon_n = 0;
    bit          mon_prev = 1'b0;
    logic [8:0]  rx_q[$];

    always @(negedge clk) begin
        if (m_busy) begin
            if (mon_n < 16) mon_bits[mon_n] = m_line;
            mon_n = mon_n + 1;
        end else if (mon_prev) begin
            rx_q.push_back({(mon_n == 10 && mon_bits[0] == 1'b0 && mon_bits[9] == 1'b1),
                            mon_bits[8:1]});
            mon_n = 0;
        end
        mon_prev = m_busy;
    end

    task automatic set_byte(input int i, input logic [7:0] b);
        bus.req_data[i*FB +: FB] = b;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '1;
        model_dead    = 1'b0;
        force_busy    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.req_ack != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy && !bus.tx_status) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.tx_start, bus.req_ack, busy, ato} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl: got start=%b ack=%b busy=%b to=%b want all 0",
                            bus.tx_start, bus.req_ack, busy, ato);
        end
        total++;
        if ({bus.tx_data, grant} !== 10'b0) begin
            bad++; $display("FAIL reset_data: got data=%h grant=%0d want 0/0", bus.tx_data, grant);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
    endtask

    task automatic test_single();
        bit ok;
        set_byte(0, 8'h55);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        total++;
        if (bus.req_ack !== 4'b0001 || bus.tx_start !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_issue: got ack=%b start=%b busy=%b want 0001/1/1",
                            bus.req_ack, bus.tx_start, busy);
        end
        bus.req_valid = '0;
        @(negedge clk);
        total++;
        if (bus.tx_start !== 1'b0 || bus.req_ack !== 4'b0000) begin
            bad++; $display("FAIL single_pulse: got start=%b ack=%b want 0/0000",
                            bus.tx_start, bus.req_ack);
        end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy); end
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h55}) begin
            bad++; $display("FAIL single_frame: got n=%0d frame=%h want 1/155",
                            rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
        end
    endtask

    task automatic test_round_robin();
        bit         ok;
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [3:0] ea;
        do_reset();
        set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
        bus.req_valid = 4'hF;
        for (int f = 0; f < 5; f++) begin
            wait_ack(ok);
            ea = 4'b0001 << exp_g[f];
            total++;
            if (!ok || grant !== exp_g[f] || bus.req_ack !== ea) begin
                bad++; $display("FAIL rr_grant%0d: got grant=%0d ack=%b want %0d/%b",
                                f, grant, bus.req_ack, exp_g[f], ea);
            end
        end
        bus.req_valid = '0;
        wait_idle(ok);
        total++;
        if (rx_q.size() != 5) begin
            bad++; $display("FAIL rr_count: got %0d frames want 5", rx_q.size());
        end
        for (int f = 0; f < 5 && f < rx_q.size(); f++) begin
            total++;
            if (rx_q[f] !== {1'b1, exp_b[f]}) begin
                bad++; $display("FAIL rr_frame%0d: got %h want %h", f, rx_q[f], {1'b1, exp_b[f]});
            end
        end
    endtask

    task automatic test_rr_order();
        bit         ok;
        logic [7:0] exp_b [3] = '{8'h77, 8'h88, 8'h66};
        do_reset();
        set_byte(2, 8'h77);
        bus.req_valid = 4'b0100;
        wait_ack(ok);
        total++;
        if (!ok || grant !== 2'd2) begin
            bad++; $display("FAIL order_first: got grant=%0d want 2", grant);
        end
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        set_byte(1, 8'h66); set_byte(3, 8'h88);
        bus.req_valid = 4'b1010;
        wait_ack(ok);
        total++;
        if (!ok || grant !== 2'd3 || bus.req_ack !== 4'b1000) begin
            bad++; $display("FAIL order_second: got grant=%0d ack=%b want 3/1000", grant, bus.req_ack);
        end
        bus.req_valid = 4'b0010;
        wait_ack(ok);
        total++;
        if (!ok || grant !== 2'd1) begin
            bad++; $display("FAIL order_third: got grant=%0d want 1", grant);
        end
        bus.req_valid = '0;
        wait_idle(ok);
        total++;
        if (rx_q.size() != 3) begin
            bad++; $display("FAIL order_count: got %0d frames want 3", rx_q.size());
        end
        for (int f = 0; f < 3 && f < rx_q.size(); f++) begin
            total++;
            if (rx_q[f] !== {1'b1, exp_b[f]}) begin
                bad++; $display("FAIL order_frame%0d: got %h want %h", f, rx_q[f], {1'b1, exp_b[f]});
            end
        end
    endtask

    task automatic test_idle_busy();
        bit ok;
        bit seen;
        do_reset();
        force_busy = 1'b1;
        set_byte(0, 8'h3C);
        bus.req_valid = 4'b0001;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.req_ack != '0 || busy) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL busy_hold: got grant while tx_status=1 want none"); end
        force_busy = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req_ack !== 4'b0001 || bus.tx_start !== 1'b1) begin
            bad++; $display("FAIL busy_release: got ack=%b start=%b want 0001/1",
                            bus.req_ack, bus.tx_start);
        end
        bus.req_valid = '0;
        wait_idle(ok);
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'h3C}) begin
            bad++; $display("FAIL busy_frame: got n=%0d want 1 frame of 3C", rx_q.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        bit idle_at_to;
        do_reset();
        model_dead = 1'b1;
        set_byte(0, 8'h99);
        bus.req_valid = 4'b0001;
        wait_ack(ok);
        bus.req_valid = '0;
        n = 0;
        idle_at_to = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n++;
            if (ato) begin idle_at_to = !busy; break; end
        end
        total++;
        if (!ok || n != TO + 1) begin
            bad++; $display("FAIL timeout_delay: got %0d cycles after ack want %0d", n, TO + 1);
        end
        total++;
        if (!idle_at_to) begin bad++; $display("FAIL timeout_idle: got busy=%b want 0", busy); end
        model_dead = 1'b0;
        set_byte(1, 8'h5E); set_byte(2, 8'hE7);
        bus.req_valid = 4'b0110;
        @(negedge clk);
        total++;
        if (ato !== 1'b0 || bus.req_ack !== 4'b0010 || grant !== 2'd1) begin
            bad++; $display("FAIL timeout_next: got to=%b ack=%b grant=%0d want 0/0010/1",
                            ato, bus.req_ack, grant);
        end
        bus.req_valid = 4'b0100;
        wait_ack(ok);
        total++;
        if (!ok || grant !== 2'd2) begin
            bad++; $display("FAIL timeout_after: got grant=%0d want 2", grant);
        end
        bus.req_valid = '0;
        wait_idle(ok);
        total++;
        if (rx_q.size() != 2 || rx_q[0] !== {1'b1, 8'h5E} || rx_q[1] !== {1'b1, 8'hE7}) begin
            bad++; $display("FAIL timeout_frames: got n=%0d want 2 frames 5E,E7", rx_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        do_reset();
        set_byte(1, 8'hB4);
        bus.req_valid = 4'b0010;
        wait_ack(ok);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        total++;
        if (!ok || busy !== 1'b1 || bus.tx_status !== 1'b1 || grant !== 2'd1) begin
            bad++; $display("FAIL midrst_pre: got busy=%b status=%b grant=%0d want 1/1/1",
                            busy, bus.tx_status, grant);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.tx_start, bus.req_ack, busy, ato, bus.tx_data, grant} !== 17'b0) begin
            bad++; $display("FAIL midrst_async: got data=%h grant=%0d busy=%b want all 0",
                            bus.tx_data, grant, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
        set_byte(0, 8'h0F); set_byte(3, 8'hF0);
        bus.req_valid = 4'b1001;
        wait_ack(ok);
        total++;
        if (!ok || grant !== 2'd0) begin
            bad++; $display("FAIL midrst_prio: got grant=%0d want 0", grant);
        end
        bus.req_valid = 4'b1000;
        wait_ack(ok);
        bus.req_valid = '0;
        wait_idle(ok);
        total++;
        if (rx_q.size() != 2 || rx_q[0] !== {1'b1, 8'h0F} || rx_q[1] !== {1'b1, 8'hF0}) begin
            bad++; $display("FAIL midrst_frames: got n=%0d want 2 frames 0F,F0", rx_q.size());
        end
    endtask

    task automatic test_packet();
        bit         ok;
        int         rem [2];
        logic [1:0] exp_g [2];
        logic [7:0] exp_b [3];
`ifdef UART_ARB_LOCK_EN
        exp_g = '{2'd1, 2'd0};
        exp_b = '{8'hA5, 8'h5A, 8'h0C};
`else
        exp_g = '{2'd0, 2'd1};
        exp_b = '{8'hA5, 8'h0C, 8'h5A};
`endif
        do_reset();
        set_byte(1, 8'hA5);
        bus.req_last  = 4'b1101;
        bus.req_valid = 4'b0010;
        wait_ack(ok);
        total++;
        if (!ok || grant !== 2'd1) begin
            bad++; $display("FAIL pkt_first: got grant=%0d want 1", grant);
        end
        set_byte(1, 8'h5A); set_byte(0, 8'h0C);
        bus.req_last  = 4'b1111;
        bus.req_valid = 4'b0011;
        rem = '{1, 1};
        for (int f = 0; f < 2; f++) begin
            wait_ack(ok);
            total++;
            if (!ok || grant !== exp_g[f]) begin
                bad++; $display("FAIL pkt_grant%0d: got %0d want %0d", f, grant, exp_g[f]);
            end
            if (grant < 2) begin
                rem[grant] = rem[grant] - 1;
                if (rem[grant] == 0) bus.req_valid[grant] = 1'b0;
            end
        end
        bus.req_valid = '0;
        wait_idle(ok);
        total++;
        if (rx_q.size() != 3) begin
            bad++; $display("FAIL pkt_count: got %0d frames want 3", rx_q.size());
        end
        for (int f = 0; f < 3 && f < rx_q.size(); f++) begin
            total++;
            if (rx_q[f] !== {1'b1, exp_b[f]}) begin
                bad++; $display("FAIL pkt_frame%0d: got %h want %h", f, rx_q[f], {1'b1, exp_b[f]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_rr_order();
        test_idle_busy();
        test_timeout();
        test_reset_midframe();
        test_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by time limit want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one `uart_tx` serializer among `N_REQ` byte producers. Accepts one byte at a time from a requester, issues the single-cycle `start` pulse to `uart_tx`, tracks `tx_status` through the frame, and re-arbitrates when the line is idle again. It sits between the system's message sources (status reporter, debug dump, command echo) and the `uart_tx` + `baud_generator` pair.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `FRAME_BITS`, 8: data bits per frame, matching `uart_tx`
- `ACK_TIMEOUT`, 16: clocks allowed for `tx_status` to rise after `tx_start`

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `req_valid`  in  N_REQ  requester i has a byte pending; held until its `req_ack` pulse
- `req_data`  in  N_REQ*FRAME_BITS  byte of requester i at bits [i*FRAME_BITS +: FRAME_BITS]; stable while `req_valid[i]`
- `req_last`  in  N_REQ  byte is the last of a packet (used only with lock feature)
- `req_ack`  out  N_REQ  one-hot, 1-cycle pulse: byte of requester i captured
- `tx_start`  out  1  to `uart_tx.start`
- `tx_data`  out  FRAME_BITS  to `uart_tx.tx_input`
- `tx_status`  in  1  from `uart_tx.tx_status` (1 = busy)
- `grant_id`  out  $clog2(N_REQ)  index of the current/last granted requester
- `busy`  out  1  arbiter not in IDLE
- `ack_timeout`  out  1  1-cycle pulse: `uart_tx` failed to go busy

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: arbitrate only when `tx_status`=0 and `|req_valid`. Winner = first set `req_valid` searching from `rr_ptr+1` upward, wrapping modulo `N_REQ`. At the edge: `tx_data`<=winner's byte, `grant_id`<=winner, `req_ack[winner]`<=1, state->ISSUE.
- ISSUE: `tx_start`=1 for exactly this cycle; `req_ack` pulse is high in this same cycle; `rr_ptr`<=`grant_id`; state->WAIT_ACK, timeout counter cleared.
- WAIT_ACK: `tx_status`=1 -> WAIT_DONE. Counter reaches `ACK_TIMEOUT` with `tx_status` still 0 -> `ack_timeout` pulse, byte dropped (already acked), state->IDLE.
- WAIT_DONE: `tx_status`=0 -> IDLE.
- `tx_data` holds its value from capture until the next capture.
- Reset values: state IDLE, `rr_ptr`=N_REQ-1 (requester 0 highest priority first), `tx_start`=0, `tx_data`=0, `req_ack`=0, `grant_id`=0, `busy`=0, `ack_timeout`=0, lock cleared.
- Reset mid-frame: arbiter returns to IDLE immediately. `uart_tx` is reset by the same net. An in-flight byte is lost and not re-acked.
- `req_valid` dropping before ack is a protocol violation. The arbiter re-samples each IDLE cycle, so a dropped request is simply not granted.
- `tx_status`=1 while in IDLE (external/leftover busy): no grant until it returns to 0.

## Timing
- `req_valid[i]` sampled high in IDLE at edge k: `req_ack[i]` and `tx_start` both high in cycle k+1. WAIT_ACK is entered at k+2.
- Back-to-back bytes: next grant is evaluated in the first IDLE cycle after `tx_status` falls, so the gap is 1 clock of IDLE plus `uart_tx` start latency.
- `busy`=1 in ISSUE, WAIT_ACK and WAIT_DONE.
- A single requester holding `req_valid` continuously is granted every frame. With multiple requesters, no requester waits more than N_REQ-1 frames.

## Configuration
- `UART_ARB_LOCK_EN` defined: packet lock. A captured byte with `req_last[g]`=0 sets lock on g. While locked, IDLE grants only g (waits for `req_valid[g]`, others ignored). The lock clears when a byte with `req_last[g]`=1 is captured, on `ack_timeout`, or on reset.
- Not defined: `req_last` is ignored and every byte is re-arbitrated round-robin.

## Test plan
- Reset, then `req_valid`=4'b0001 with byte 0x55 -> `req_ack`=0001 and `tx_start` in the same cycle. The serial line decodes 0x55 with start=0 and stop=1. `busy` returns to 0 after `tx_status` falls.
- All four requesters valid (0x11, 0x22, 0x33, 0x44) and held -> frames decode in order 0x11, 0x22, 0x33, 0x44, then 0x11 again. `grant_id` sequence is 0, 1, 2, 3, 0.
- Requester 2 granted, then requesters 1 and 3 valid -> 3 is served before 1 (round-robin from `rr_ptr`=2).
- `tx_status` tied 0 -> `ack_timeout` pulses exactly `ACK_TIMEOUT` clocks after WAIT_ACK entry, then the arbiter is back in IDLE and serves the next requester.
- `reset` asserted during WAIT_DONE -> all outputs go to reset values asynchronously. After release, requester 0 has priority.
- With `UART_ARB_LOCK_EN`: requester 1 sends 0xA5 (last=0) then 0x5A (last=1) while requester 0 is valid throughout -> both requester 1 bytes are transmitted before any requester 0 byte.
